// File: rtl/complete_datapath_if.sv
// Control and status bundle between an external control unit and complete_datapath.
// master = control unit / bench side, slave = datapath side.
interface complete_datapath_if;
   logic        i_pc_ce;
   logic [1:0]  i_pc_sel;
   logic        i_pc_add_src;
   logic        i_pc_alu_sel;
   logic        i_mem_addr_sel;
   logic [15:0] i_ext_mem_addr;
   logic        i_memw_data_sel;
   logic [15:0] i_ext_memw_data;
   logic        i_memw_en;
   logic        i_rd_rm_sel;
   logic        i_rf_write_en;
   logic [1:0]  i_rf_write_data_sel;
   logic [1:0]  i_imm_sel;
   logic [1:0]  i_alu_b_sel;
   logic        i_alu_control;
   logic        i_aluout_reg_ce;
   logic        i_rd_reg_ce;
   logic        i_z_ce;
   logic        i_c_ce;
   logic        i_out_r_ce;

   logic [15:0] o_pc_out;
   logic [15:0] o_mem_data_reg;
   logic [15:0] o_imm_out_c;
   logic [4:0]  o_opcode;
   logic [2:0]  o_rd_addr;
   logic [2:0]  o_rm_addr;
   logic [2:0]  o_rn_addr;
   logic [1:0]  o_alu_op;
   logic [10:0] o_pc_label11;
   logic        o_z_reg;
   logic        o_c_reg;
   logic [15:0] o_out_r;

   modport master (
      output i_pc_ce, i_pc_sel, i_pc_add_src, i_pc_alu_sel, i_mem_addr_sel,
             i_ext_mem_addr, i_memw_data_sel, i_ext_memw_data, i_memw_en,
             i_rd_rm_sel, i_rf_write_en, i_rf_write_data_sel, i_imm_sel,
             i_alu_b_sel, i_alu_control, i_aluout_reg_ce, i_rd_reg_ce,
             i_z_ce, i_c_ce, i_out_r_ce,
      input  o_pc_out, o_mem_data_reg, o_imm_out_c, o_opcode, o_rd_addr,
             o_rm_addr, o_rn_addr, o_alu_op, o_pc_label11, o_z_reg, o_c_reg,
             o_out_r
   );

   modport slave (
      input  i_pc_ce, i_pc_sel, i_pc_add_src, i_pc_alu_sel, i_mem_addr_sel,
             i_ext_mem_addr, i_memw_data_sel, i_ext_memw_data, i_memw_en,
             i_rd_rm_sel, i_rf_write_en, i_rf_write_data_sel, i_imm_sel,
             i_alu_b_sel, i_alu_control, i_aluout_reg_ce, i_rd_reg_ce,
             i_z_ce, i_c_ce, i_out_r_ce,
      output o_pc_out, o_mem_data_reg, o_imm_out_c, o_opcode, o_rd_addr,
             o_rm_addr, o_rn_addr, o_alu_op, o_pc_label11, o_z_reg, o_c_reg,
             o_out_r
   );
endinterface

// File: rtl/complete_datapath.sv
// Multi-cycle 16-bit RISC datapath (PC, IR, 8x16 RF, add/sub ALU, unified RAM), externally sequenced.
// Optional macro DATAPATH_CARRY_CHAIN_EN: ADC/SBB take carry-in from C_Reg when Opcode==0 and ALU_Op[0]=1.
module complete_datapath #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   complete_datapath_if.slave  bus
);
   localparam int unsigned DW    = 16;
   localparam int unsigned NREG  = 8;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DW-1:0]     r_pc;
   logic [DW-1:0]     r_ir;
   logic [DW-1:0]     r_mem_data;
   logic [DW-1:0]     r_aluout;
   logic [DW-1:0]     r_rd_reg;
   logic [DW-1:0]     r_out;
   logic              r_z;
   logic              r_c;
   logic [DW-1:0]     r_rf  [NREG];
   logic [DW-1:0]     r_mem [DEPTH];

   logic [2:0]        w_rd;
   logic [2:0]        w_rm;
   logic [2:0]        w_rn;
   logic [2:0]        w_ra_addr;
   logic [DW-1:0]     w_read_a;
   logic [DW-1:0]     w_read_b;
   logic [DW-1:0]     w_imm;
   logic [DW-1:0]     w_branch_off;
   logic [DW-1:0]     w_pc_add;
   logic [DW-1:0]     w_pc_next;
   logic [DW-1:0]     w_addr;
   logic [ADDR_W-1:0] w_mem_idx;
   logic [DW-1:0]     w_memr_data;
   logic [DW-1:0]     w_memw_data;
   logic [DW-1:0]     w_alu_b;
   logic [DW-1:0]     w_alu_b_eff;
   logic              w_cin;
   logic [DW:0]       w_sum;
   logic [DW-1:0]     w_alu_res;
   logic [DW-1:0]     w_rf_wdata;

   assign w_rd      = r_ir[10:8];
   assign w_rm      = r_ir[7:5];
   assign w_rn      = r_ir[4:2];
   assign w_ra_addr = bus.i_rd_rm_sel ? w_rm : w_rd;
   assign w_read_a  = r_rf[w_ra_addr];
   assign w_read_b  = r_rf[w_rn];

   // Immediate formats; 11 builds an LHI value from the low byte of the target register
   always_comb begin
      w_imm = '0;
      case (bus.i_imm_sel)
         2'b00:   w_imm = {11'b0, r_ir[4:0]};
         2'b01:   w_imm = {{8{r_ir[7]}}, r_ir[7:0]};
         2'b10:   w_imm = {8'b0, r_ir[7:0]};
         default: w_imm = {r_ir[7:0], w_read_a[7:0]};
      endcase
   end

   assign w_branch_off = {{8{r_ir[7]}}, r_ir[7:0]};
   assign w_pc_add     = bus.i_pc_add_src ? (r_pc + w_branch_off) : (r_pc + 16'd1);

   always_comb begin
      w_pc_next = '0;
      case (bus.i_pc_sel)
         2'b00:   w_pc_next = w_pc_add;
         2'b01:   w_pc_next = {r_pc[15:11], r_ir[10:0]};
         2'b10:   w_pc_next = r_rd_reg;
         default: w_pc_next = '0;
      endcase
   end

   // Unified RAM: external port wins, otherwise PC (fetch) or ALUOut (load/store)
   assign w_addr      = bus.i_mem_addr_sel ? bus.i_ext_mem_addr
                      : (bus.i_pc_alu_sel ? r_aluout : r_pc);
   assign w_mem_idx   = w_addr[ADDR_W-1:0];
   assign w_memr_data = r_mem[w_mem_idx];
   assign w_memw_data = bus.i_memw_data_sel ? bus.i_ext_memw_data : w_read_a;

   if (ADDR_W < DW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^w_addr[DW-1:ADDR_W];
   end

   always_comb begin
      w_alu_b = '0;
      case (bus.i_alu_b_sel)
         2'b00:   w_alu_b = w_read_b;
         2'b01:   w_alu_b = w_imm;
         default: w_alu_b = '0;
      endcase
   end

`ifdef DATAPATH_CARRY_CHAIN_EN
   assign w_cin = ((r_ir[15:11] == 5'd0) && r_ir[0]) ? r_c : bus.i_alu_control;
`else
   assign w_cin = bus.i_alu_control;
`endif

   // Subtract is A + ~B + cin; carry is bit 16 of the 17-bit sum
   assign w_alu_b_eff = bus.i_alu_control ? ~w_alu_b : w_alu_b;
   assign w_sum       = 17'(w_read_a) + 17'(w_alu_b_eff) + 17'(w_cin);
   assign w_alu_res   = w_sum[DW-1:0];

   always_comb begin
      w_rf_wdata = '0;
      case (bus.i_rf_write_data_sel)
         2'b00:   w_rf_wdata = w_memr_data;
         2'b01:   w_rf_wdata = w_imm;
         2'b10:   w_rf_wdata = r_aluout;
         default: w_rf_wdata = r_pc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= '0;
         r_ir       <= '0;
         r_mem_data <= '0;
         r_aluout   <= '0;
         r_rd_reg   <= '0;
         r_out      <= '0;
         r_z        <= 1'b0;
         r_c        <= 1'b0;
      end else begin
         r_mem_data <= w_memr_data;
         if (bus.i_pc_ce) begin
            r_pc <= w_pc_next;
            r_ir <= w_memr_data;
         end
         if (bus.i_aluout_reg_ce) r_aluout <= w_alu_res;
         if (bus.i_z_ce)          r_z      <= (w_alu_res == '0);
         if (bus.i_c_ce)          r_c      <= w_sum[DW];
         if (bus.i_rd_reg_ce)     r_rd_reg <= w_read_a;
         if (bus.i_out_r_ce)      r_out    <= w_read_a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (bus.i_rf_write_en) begin
         r_rf[w_rd] <= w_rf_wdata;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (bus.i_memw_en) r_mem[w_mem_idx] <= w_memw_data;
   end

   assign bus.o_pc_out       = r_pc;
   assign bus.o_mem_data_reg = r_mem_data;
   assign bus.o_imm_out_c    = w_imm;
   assign bus.o_opcode       = r_ir[15:11];
   assign bus.o_rd_addr      = w_rd;
   assign bus.o_rm_addr      = w_rm;
   assign bus.o_rn_addr      = w_rn;
   assign bus.o_alu_op       = r_ir[1:0];
   assign bus.o_pc_label11   = r_ir[10:0];
   assign bus.o_z_reg        = r_z;
   assign bus.o_c_reg        = r_c;
   assign bus.o_out_r        = r_out;
endmodule

// File: tb/tb_complete_datapath.sv
// Self-checking bench for complete_datapath: directed sequences, an ALU vector table,
// and randomized control streams compared against an arithmetic reference model.
module tb_complete_datapath;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   complete_datapath_if bus();
   complete_datapath #(.ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_mem [256];
   logic [15:0] m_rf  [8];
   logic [15:0] m_pc, m_ir, m_md, m_alu, m_rdr, m_out;
   logic        m_z, m_c;

   typedef struct {
      logic        sub;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        z;
      logic        c;
   } alu_vec_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.i_pc_ce = 0; bus.i_pc_sel = 0; bus.i_pc_add_src = 0; bus.i_pc_alu_sel = 0;
      bus.i_mem_addr_sel = 0; bus.i_ext_mem_addr = 0; bus.i_memw_data_sel = 0;
      bus.i_ext_memw_data = 0; bus.i_memw_en = 0; bus.i_rd_rm_sel = 0;
      bus.i_rf_write_en = 0; bus.i_rf_write_data_sel = 0; bus.i_imm_sel = 0;
      bus.i_alu_b_sel = 0; bus.i_alu_control = 0; bus.i_aluout_reg_ce = 0;
      bus.i_rd_reg_ce = 0; bus.i_z_ce = 0; bus.i_c_ce = 0; bus.i_out_r_ce = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ext_write(input logic [15:0] a, input logic [15:0] d);
      idle();
      bus.i_mem_addr_sel = 1; bus.i_ext_mem_addr = a;
      bus.i_memw_data_sel = 1; bus.i_ext_memw_data = d; bus.i_memw_en = 1;
      step();
      idle();
   endtask

   task automatic ext_read(input string name, input logic [15:0] a, input logic [15:0] exp);
      idle();
      bus.i_mem_addr_sel = 1; bus.i_ext_mem_addr = a;
      step();
      check(name, bus.o_mem_data_reg, exp);
      idle();
   endtask

   // Forces PC/IR by fetching through the external address port (scratch words 0xF0/0xF1)
   task automatic load_ir_pc(input logic [10:0] pc, input logic [15:0] ir);
      ext_write(16'h00F0, {5'b0, pc});
      ext_write(16'h00F1, ir);
      bus.i_pc_ce = 1; bus.i_mem_addr_sel = 1;
      bus.i_ext_mem_addr = 16'h00F0; bus.i_pc_sel = 2'b11;
      step();
      bus.i_ext_mem_addr = 16'h00F1; bus.i_pc_sel = 2'b01;
      step();
      idle();
   endtask

   task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
      load_ir_pc(11'd0, {5'b0, r, v[7:0]});
      bus.i_rf_write_en = 1; bus.i_rf_write_data_sel = 2'b01; bus.i_imm_sel = 2'b10;
      step();
      load_ir_pc(11'd0, {5'b0, r, v[15:8]});
      bus.i_rf_write_en = 1; bus.i_rf_write_data_sel = 2'b01; bus.i_imm_sel = 2'b11;
      step();
      idle();
   endtask

   task automatic read_reg(input string name, input logic [2:0] r, input logic [15:0] exp);
      load_ir_pc(11'd0, {5'b0, r, 8'h00});
      bus.i_out_r_ce = 1;
      step();
      check(name, bus.o_out_r, exp);
      idle();
   endtask

   function automatic int model_imm(input logic [1:0] sel, input logic [15:0] ir, input int a);
      int v;
      case (sel)
         2'd0:    v = int'(ir) % 32;
         2'd1:    v = (int'(ir[7:0]) >= 128) ? int'(ir[7:0]) + 65280 : int'(ir[7:0]);
         2'd2:    v = int'(ir) % 256;
         default: v = (int'(ir) % 256) * 256 + a % 256;
      endcase
      return v;
   endfunction

   // One clock of the reference model, driven by the controls currently on the bus
   task automatic model_cycle();
      int ra, a, bb, imm, addr, memr, bop, cin, sum, res, off, npc, wd;
      ra   = bus.i_rd_rm_sel ? int'(m_ir[7:5]) : int'(m_ir[10:8]);
      a    = int'(m_rf[ra]);
      bb   = int'(m_rf[m_ir[4:2]]);
      imm  = model_imm(bus.i_imm_sel, m_ir, a);
      if (bus.i_mem_addr_sel)    addr = int'(bus.i_ext_mem_addr);
      else if (bus.i_pc_alu_sel) addr = int'(m_alu);
      else                       addr = int'(m_pc);
      addr = addr % 256;
      memr = int'(m_mem[addr]);
      if (bus.i_alu_b_sel[1])      bop = 0;
      else if (bus.i_alu_b_sel[0]) bop = imm;
      else                         bop = bb;
      cin = bus.i_alu_control ? 1 : 0;
`ifdef DATAPATH_CARRY_CHAIN_EN
      if (m_ir[15:11] == 5'd0 && m_ir[0]) cin = m_c ? 1 : 0;
`endif
      sum = bus.i_alu_control ? a + (65535 - bop) + cin : a + bop + cin;
      res = sum % 65536;
      off = int'(m_ir[7:0]);
      if (off >= 128) off = off - 256;
      case (bus.i_pc_sel)
         2'd0:    npc = (int'(m_pc) + (bus.i_pc_add_src ? off : 1) + 65536) % 65536;
         2'd1:    npc = (int'(m_pc) / 2048) * 2048 + int'(m_ir) % 2048;
         2'd2:    npc = int'(m_rdr);
         default: npc = 0;
      endcase
      case (bus.i_rf_write_data_sel)
         2'd0:    wd = memr;
         2'd1:    wd = imm;
         2'd2:    wd = int'(m_alu);
         default: wd = int'(m_pc);
      endcase
      if (bus.i_memw_en) m_mem[addr] = bus.i_memw_data_sel ? bus.i_ext_memw_data : 16'(a);
      if (bus.i_rf_write_en)   m_rf[m_ir[10:8]] = 16'(wd);
      if (bus.i_aluout_reg_ce) m_alu = 16'(res);
      if (bus.i_z_ce)          m_z = (res == 0);
      if (bus.i_c_ce)          m_c = (sum >= 65536);
      if (bus.i_rd_reg_ce)     m_rdr = 16'(a);
      if (bus.i_out_r_ce)      m_out = 16'(a);
      m_md = 16'(memr);
      if (bus.i_pc_ce) begin
         m_pc = 16'(npc);
         m_ir = 16'(memr);
      end
   endtask

   task automatic rand_controls();
      bus.i_pc_ce = 1'($urandom); bus.i_pc_sel = 2'($urandom);
      bus.i_pc_add_src = 1'($urandom); bus.i_pc_alu_sel = 1'($urandom);
      bus.i_mem_addr_sel = 1'($urandom); bus.i_ext_mem_addr = 16'($urandom);
      bus.i_memw_data_sel = 1'($urandom); bus.i_ext_memw_data = 16'($urandom);
      bus.i_memw_en = ($urandom_range(0, 3) == 0);
      bus.i_rd_rm_sel = 1'($urandom); bus.i_rf_write_en = 1'($urandom);
      bus.i_rf_write_data_sel = 2'($urandom); bus.i_imm_sel = 2'($urandom);
      bus.i_alu_b_sel = 2'($urandom); bus.i_alu_control = 1'($urandom);
      bus.i_aluout_reg_ce = 1'($urandom); bus.i_rd_reg_ce = 1'($urandom);
      bus.i_z_ce = 1'($urandom); bus.i_c_ce = 1'($urandom); bus.i_out_r_ce = 1'($urandom);
   endtask

   initial begin
      alu_vec_t vecs [7];
      int ra;
      vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", bus.o_pc_out, 16'h0000);
      check("reset_opcode", 16'(bus.o_opcode), 16'h0000);
      check("reset_out_r", bus.o_out_r, 16'h0000);
      check("reset_zc", {14'b0, bus.o_z_reg, bus.o_c_reg}, 16'h0000);
      rst = 1'b0;

      // Fetch then LLI/LHI
      ext_write(16'h0000, 16'h1025);
      bus.i_pc_ce = 1;
      step();
      check("fetch_pc", bus.o_pc_out, 16'h0001);
      check("fetch_opcode", 16'(bus.o_opcode), 16'h0002);
      check("fetch_rd", 16'(bus.o_rd_addr), 16'h0000);
      idle();
      bus.i_rf_write_en = 1; bus.i_rf_write_data_sel = 2'b01; bus.i_imm_sel = 2'b10;
      step();
      idle();
      bus.i_out_r_ce = 1;
      step();
      check("lli_out_r", bus.o_out_r, 16'h0025);
      load_ir_pc(11'd0, 16'h0863);
      bus.i_rf_write_en = 1; bus.i_rf_write_data_sel = 2'b01; bus.i_imm_sel = 2'b11;
      #1;
      check("lhi_imm", bus.o_imm_out_c, 16'h6325);
      step();
      read_reg("lhi_r0", 3'd0, 16'h6325);

      // Load then store through ALUOut addressing
      ext_write(16'h0040, 16'h0047);
      set_reg(3'd0, 16'h0040);
      load_ir_pc(11'd0, 16'h1900);
      bus.i_rd_rm_sel = 1; bus.i_alu_b_sel = 2'b01; bus.i_imm_sel = 2'b00;
      bus.i_aluout_reg_ce = 1;
      step();
      idle();
      bus.i_pc_alu_sel = 1; bus.i_rf_write_en = 1; bus.i_rf_write_data_sel = 2'b00;
      step();
      idle();
      read_reg("ldr_r1", 3'd1, 16'h0047);
      load_ir_pc(11'd0, 16'h1901);
      bus.i_rd_rm_sel = 1; bus.i_alu_b_sel = 2'b01; bus.i_imm_sel = 2'b00;
      bus.i_aluout_reg_ce = 1;
      step();
      idle();
      bus.i_pc_alu_sel = 1; bus.i_memw_en = 1; bus.i_memw_data_sel = 0;
      step();
      ext_read("str_mem41", 16'h0041, 16'h0047);

      // ALU vector table: R1 op R2 -> ALUOut -> R0 -> Out_R
      for (int i = 0; i < 7; i++) begin
         set_reg(3'd1, vecs[i].a);
         set_reg(3'd2, vecs[i].b);
         load_ir_pc(11'd0, 16'h0028);
         bus.i_rd_rm_sel = 1; bus.i_alu_control = vecs[i].sub;
         bus.i_aluout_reg_ce = 1; bus.i_z_ce = 1; bus.i_c_ce = 1;
         step();
         check($sformatf("alu%0d_z", i), 16'(bus.o_z_reg), 16'(vecs[i].z));
         check($sformatf("alu%0d_c", i), 16'(bus.o_c_reg), 16'(vecs[i].c));
         idle();
         bus.i_rf_write_en = 1; bus.i_rf_write_data_sel = 2'b10;
         step();
         idle();
         bus.i_out_r_ce = 1;
         step();
         check($sformatf("alu%0d_res", i), bus.o_out_r, vecs[i].res);
         idle();
      end

      // PC source selection
      ext_write(16'h00F2, 16'h800A);
      load_ir_pc(11'h01D, 16'hC3FC);
      check("br_pc_pre", bus.o_pc_out, 16'h001D);
      bus.i_pc_ce = 1; bus.i_pc_add_src = 1; bus.i_mem_addr_sel = 1;
      bus.i_ext_mem_addr = 16'h00F2;
      step();
      check("br_pc_back", bus.o_pc_out, 16'h0019);
      check("br_label", 16'(bus.o_pc_label11), 16'h000A);
      idle();
      bus.i_pc_ce = 1; bus.i_pc_sel = 2'b01;
      step();
      check("jmp_pc", bus.o_pc_out, 16'h000A);
      set_reg(3'd3, 16'h0030);
      bus.i_rd_reg_ce = 1;
      step();
      idle();
      bus.i_pc_ce = 1; bus.i_pc_sel = 2'b10;
      step();
      check("jr_pc", bus.o_pc_out, 16'h0030);
      bus.i_pc_sel = 2'b11;
      step();
      check("zero_pc", bus.o_pc_out, 16'h0000);

      // Fetch and write of the same word on one edge: IR sees the old word
      idle();
      bus.i_pc_ce = 1; bus.i_mem_addr_sel = 1; bus.i_ext_mem_addr = 16'h0000;
      bus.i_memw_en = 1; bus.i_memw_data_sel = 1; bus.i_ext_memw_data = 16'h5555;
      step();
      check("rw_same_edge_ir", 16'(bus.o_opcode), 16'h0002);
      ext_read("rw_same_edge_mem", 16'h0000, 16'h5555);

      // Reset in the middle of activity
      set_reg(3'd0, 16'h1234);
      bus.i_out_r_ce = 1; bus.i_alu_b_sel = 2'b10; bus.i_alu_control = 1;
      bus.i_c_ce = 1; bus.i_aluout_reg_ce = 1;
      step();
      check("pre_rst_out_r", bus.o_out_r, 16'h1234);
      check("pre_rst_c", 16'(bus.o_c_reg), 16'h0001);
      bus.i_pc_ce = 1;
      rst = 1'b1;
      #1;
      check("rst_pc", bus.o_pc_out, 16'h0000);
      check("rst_out_r", bus.o_out_r, 16'h0000);
      check("rst_c", 16'(bus.o_c_reg), 16'h0000);
      check("rst_md", bus.o_mem_data_reg, 16'h0000);
      check("rst_ir", {bus.o_opcode, bus.o_pc_label11}, 16'h0000);
      idle();
      @(negedge clk);
      rst = 1'b0;
      bus.i_out_r_ce = 1;
      step();
      check("rst_r0", bus.o_out_r, 16'h0000);
      idle();
      bus.i_pc_ce = 1;
      step();
      check("rst_fetch_pc", bus.o_pc_out, 16'h0001);
      check("rst_fetch_opc", 16'(bus.o_opcode), 16'h000A);
      ext_read("rst_ram_kept", 16'h0041, 16'h0047);

      // Randomized control streams against the reference model
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_pc = '0; m_ir = '0; m_md = '0; m_alu = '0; m_rdr = '0; m_out = '0;
      m_z = 1'b0; m_c = 1'b0;
      for (int i = 0; i < 256; i++) begin
         m_mem[i] = 16'($urandom);
         ext_write(16'(i), m_mem[i]);
      end
      m_md = m_mem[255];
      for (int n = 0; n < 600; n++) begin
         rand_controls();
         model_cycle();
         step();
         check("rnd_pc", bus.o_pc_out, m_pc);
         check("rnd_ir", {bus.o_opcode, bus.o_rd_addr, bus.o_rm_addr, bus.o_rn_addr, bus.o_alu_op}, m_ir);
         check("rnd_md", bus.o_mem_data_reg, m_md);
         check("rnd_out_r", bus.o_out_r, m_out);
         check("rnd_zc", {14'b0, bus.o_z_reg, bus.o_c_reg}, {14'b0, m_z, m_c});
         ra = bus.i_rd_rm_sel ? int'(m_ir[7:5]) : int'(m_ir[10:8]);
         check("rnd_imm", bus.o_imm_out_c, 16'(model_imm(bus.i_imm_sel, m_ir, int'(m_rf[ra]))));
      end
      for (int r = 0; r < 8; r++) read_reg($sformatf("rnd_rf%0d", r), 3'(r), m_rf[r]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/complete_datapath.md
# complete_datapath

Multi-cycle 16-bit RISC datapath: PC, instruction register, 8×16 register file, add/sub ALU with Z/C flags, unified instruction/data RAM, and an output register. It holds no control FSM; an external control unit (or bench) drives every select and enable line each cycle and reads back the decoded instruction fields. External address/data ports let the bench load memory before execution.

## Interface
- ADDR_W, 8, RAM address width (depth 2^ADDR_W words; upper address bits ignored)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-high
- PC_CE  in  1  PC load enable; also loads IR
- PC_Sel  in  2  00 PC-adder, 01 {PC[15:11],IR[10:0]}, 10 Rd_Reg, 11 zero
- PC_Add_Src  in  1  0 PC+1, 1 PC+sext(IR[7:0])
- PC_ALU_Sel  in  1  memory address: 0 PC_Out, 1 ALUOut register
- Mem_Addr_Sel  in  1  1 overrides address with Ext_Mem_Addr
- Ext_Mem_Addr  in  16  external address
- MemW_Data_Sel  in  1  0 ReadA_Data, 1 Ext_MemW_Data
- Ext_MemW_Data  in  16  external write data
- MemW_en  in  1  RAM write enable
- Rd_Rm_Sel  in  1  read port A address: 0 Rd, 1 Rm
- RF_Write_en  in  1  register-file write (address Rd)
- RF_Write_Data_Sel  in  2  00 MemR_Data, 01 Imm_Out, 10 ALUOut reg, 11 PC_Out
- Imm_Sel  in  2  00 zext IR[4:0], 01 sext IR[7:0], 10 zext IR[7:0], 11 {IR[7:0],ReadA_Data[7:0]}
- ALU_B_Sel  in  2  00 ReadB_Data, 01 Imm_Out, 1x 0
- ALU_Control  in  1  0 add, 1 subtract
- ALUOut_Reg_CE, Rd_Reg_CE, Z_CE, C_CE, Out_R_CE  in  1 each  register enables
- PC_Out  out  16  PC
- Mem_Data_Reg  out  16  registered RAM read data
- Imm_Out  out  16  immediate mux
- Opcode  out  5  IR[15:11]; Rd_Addr out 3 IR[10:8]; Rm_Addr out 3 IR[7:5]; Rn_Addr out 3 IR[4:2]; ALU_Op out 2 IR[1:0]; PC_Label11 out 11 IR[10:0]
- Z_Reg, C_Reg  out  1 each  flags
- Out_R  out  16  output register

## Operation
- RAM: asynchronous read MemR_Data = mem[addr]; synchronous write at posedge when MemW_en. addr = Mem_Addr_Sel ? Ext_Mem_Addr : (PC_ALU_Sel ? ALUOut : PC_Out).
- IR loads MemR_Data when PC_CE=1 (fetch); Mem_Data_Reg loads MemR_Data every cycle.
- Register file: two async read ports (A = Rd or Rm, B = Rn), one sync write port at Rd_Addr.
- ALU: A = ReadA_Data, B per ALU_B_Sel. Add: A+B+cin; subtract: A+~B+cin. cin = 0 add, 1 subtract (see Configuration). C = carry-out bit 16; Z = (result==0). ALUOut reg loads result on ALUOut_Reg_CE; Z/C load on Z_CE/C_CE independently.
- Rd_Reg loads ReadA_Data on Rd_Reg_CE. Out_R loads ReadA_Data on Out_R_CE.
- Branch offset always sext(IR[7:0]), independent of Imm_Sel. All arithmetic mod 2^16.
- Same-edge RAM write and read: read returns old data until the edge; PC_CE with write to current PC loads the pre-write word into IR.

## Timing
- All registers posedge clk. Reset clears PC, IR, Mem_Data_Reg, ALUOut, Rd_Reg, Z, C, Out_R and all 8 registers to 0 immediately; RAM contents unchanged. Reset mid-sequence abandons it; first post-reset fetch is address 0.
- Register-to-register ops (LLI/LHI/MOV-via-Imm) complete in 1 cycle; ALU ops and loads/stores take 2 (ALUOut capture, then write/memory access).
- Decoded fields change only on cycles with PC_CE=1.

## Configuration
- DATAPATH_CARRY_CHAIN_EN defined: when Opcode==00000 and ALU_Op[0]=1, cin = C_Reg (ADC: A+B+C; SBB: A+~B+C). Undefined: cin fixed by ALU_Control only; ALU_Op ignored.

## Test plan
- Ext-write 0x1025 to 0x00, fetch (PC_CE, PC_Sel=00) -> PC=1, Opcode=00010, Rd_Addr=0; LLI (Imm_Sel=10, sel 01, RF write) then Out_R_CE -> Out_R=0x0025.
- With R0=0x0025, IR=0x0863, LHI (Imm_Sel=11) -> R0=0x6325.
- mem[0x40]=0x0047, R0=0x0040, IR=0x1900: ALU_B=imm, ALUOut CE, then PC_ALU_Sel=1, sel 00 write -> R1=0x0047; STR path writes ReadA_Data back to 0x41.
- R1=0xFFFF, R2=0x0001 add with Z_CE/C_CE -> result 0, Z=1, C=1; subtract 5-5 -> 0, Z=1, C=1; 3-5 -> 0xFFFE, C=0.
- PC=0x1D, IR=0xC3FC, PC_Add_Src=1 -> PC=0x19; IR=0x800A, PC_Sel=01 -> PC=0x000A; Rd_Reg=0x0030, PC_Sel=10 -> 0x0030; PC_Sel=11 -> 0.
- Assert rst mid-operation with nonzero registers -> all registers/flags/Out_R read 0 before next edge; RAM retains data.
